mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one shared single-port memory.
// Data side has priority; a waiting fetch is forced through after STARVE_LIMIT data grants.
module mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [DATA_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ready,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [DATA_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    input  logic [3:0]            dm_be,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_ready,
    output logic                  mem_valid,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                  state_reg,     state_next;
    logic [CW-1:0]           starve_reg,    starve_next;
    logic                    mem_valid_reg, mem_valid_next;
    logic                    mem_we_reg,    mem_we_next;
    logic [DATA_WIDTH-1:0]   mem_addr_reg,  mem_addr_next;
    logic [DATA_WIDTH-1:0]   mem_wdata_reg, mem_wdata_next;
    logic [3:0]              mem_be_reg,    mem_be_next;
    logic                    if_ready_reg,  if_ready_next;
    logic                    dm_ready_reg,  dm_ready_next;
    logic [DATA_WIDTH-1:0]   if_rdata_reg,  if_rdata_next;
    logic [DATA_WIDTH-1:0]   dm_rdata_reg,  dm_rdata_next;

    logic                    fetch_forced;

    // The fetch only overrides the data side once it has been starved to the limit.
    assign fetch_forced = if_req && (starve_reg == LIMIT);

    always_comb begin
        state_next     = state_reg;
        starve_next    = starve_reg;
        mem_valid_next = mem_valid_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_be_next    = mem_be_reg;
        if_ready_next  = 1'b0;
        dm_ready_next  = 1'b0;
        if_rdata_next  = if_rdata_reg;
        dm_rdata_next  = dm_rdata_reg;

        case (state_reg)
            IDLE: begin
                if (dm_req && !fetch_forced) begin
                    state_next     = DM_BUSY;
                    mem_valid_next = 1'b1;
                    mem_we_next    = dm_we;
                    mem_addr_next  = dm_addr;
                    mem_wdata_next = dm_wdata;
                    mem_be_next    = dm_be;
                    if (if_req) begin
                        starve_next = (starve_reg == LIMIT) ? starve_reg : starve_reg + CW'(1);
                    end else begin
                        starve_next = '0;
                    end
                end else if (if_req) begin
                    state_next     = IF_BUSY;
                    mem_valid_next = 1'b1;
                    mem_we_next    = 1'b0;
                    mem_addr_next  = if_addr;
                    mem_wdata_next = '0;
                    mem_be_next    = 4'hF;
                    starve_next    = '0;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (mem_ready) begin
                    state_next     = DONE;
                    mem_valid_next = 1'b0;
                    if (state_reg == IF_BUSY) begin
                        if_ready_next = 1'b1;
                        if_rdata_next = mem_rdata;
                    end else begin
                        dm_ready_next = 1'b1;
                        // Stores leave the last load result visible.
                        if (!mem_we_reg) begin
                            dm_rdata_next = mem_rdata;
                        end
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            starve_reg    <= '0;
            mem_valid_reg <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_be_reg    <= 4'h0;
            if_ready_reg  <= 1'b0;
            dm_ready_reg  <= 1'b0;
            if_rdata_reg  <= '0;
            dm_rdata_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            starve_reg    <= starve_next;
            mem_valid_reg <= mem_valid_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_be_reg    <= mem_be_next;
            if_ready_reg  <= if_ready_next;
            dm_ready_reg  <= dm_ready_next;
            if_rdata_reg  <= if_rdata_next;
            dm_rdata_reg  <= dm_rdata_next;
        end
    end

    assign mem_valid = mem_valid_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_be    = mem_be_reg;
    assign if_ready  = if_ready_reg;
    assign dm_ready  = dm_ready_reg;
    assign if_rdata  = if_rdata_reg;
    assign dm_rdata  = dm_rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// against a bench-side memory and an arbitration reference model.
module tb_mem_arbiter;

    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [DW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          dm_req;
    logic          dm_we;
    logic [DW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [3:0]    dm_be;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;
    logic          mem_valid;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_be;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mem_model [0:127];

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_be     (dm_be),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        dm_be     = 4'h0;
        mem_ready = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst    = 1'b1;
        if_req = 1'b1;
        dm_req = 1'b1;
        step();
        step();
        vectors++;
        if ({mem_valid, mem_we, mem_addr, mem_wdata, mem_be} !== '0) begin
            miscompares++;
            $display("FAIL reset_mem got valid=%b we=%b addr=%h wdata=%h be=%h exp all zero",
                     mem_valid, mem_we, mem_addr, mem_wdata, mem_be);
        end
        vectors++;
        if ({if_ready, dm_ready, if_rdata, dm_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_ports got if_ready=%b dm_ready=%b if_rdata=%h dm_rdata=%h exp all zero",
                     if_ready, dm_ready, if_rdata, dm_rdata);
        end
        idle_inputs();
    endtask

    // Fetch granted on the very first edge after reset is released.
    task automatic test_fetch();
        rst     = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h100;
        step();
        vectors++;
        if ({mem_valid, mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, 1'b0, 32'h100, 32'h0, 4'hF}) begin
            miscompares++;
            $display("FAIL fetch_cmd got valid=%b we=%b addr=%h wdata=%h be=%h exp 1 0 00000100 00000000 f",
                     mem_valid, mem_we, mem_addr, mem_wdata, mem_be);
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h00500093;
        step();
        vectors++;
        if ({if_ready, dm_ready, mem_valid} !== 3'b100 || if_rdata !== 32'h00500093) begin
            miscompares++;
            $display("FAIL fetch_done got if_ready=%b dm_ready=%b valid=%b if_rdata=%h exp 1 0 0 00500093",
                     if_ready, dm_ready, mem_valid, if_rdata);
        end
        if_req    = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        step();
        vectors++;
        if ({if_ready, mem_valid} !== 2'b00 || if_rdata !== 32'h00500093) begin
            miscompares++;
            $display("FAIL fetch_after got if_ready=%b valid=%b if_rdata=%h exp 0 0 00500093",
                     if_ready, mem_valid, if_rdata);
        end
    endtask

    // dm_req stays high across completion with a new address: one fresh grant from IDLE.
    task automatic test_back_to_back();
        dm_req   = 1'b1;
        dm_we    = 1'b0;
        dm_addr  = 32'h2000;
        dm_wdata = 32'h55;
        dm_be    = 4'hF;
        step();
        vectors++;
        if ({mem_valid, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h2000}) begin
            miscompares++;
            $display("FAIL b2b_cmd1 got valid=%b we=%b addr=%h exp 1 0 00002000", mem_valid, mem_we, mem_addr);
        end
        mem_ready = 1'b1;
        mem_rdata = 32'hAAAA5555;
        step();
        vectors++;
        if ({dm_ready, if_ready} !== 2'b10 || dm_rdata !== 32'hAAAA5555 || if_rdata !== 32'h00500093) begin
            miscompares++;
            $display("FAIL b2b_done1 got dm_ready=%b if_ready=%b dm_rdata=%h if_rdata=%h exp 1 0 aaaa5555 00500093",
                     dm_ready, if_ready, dm_rdata, if_rdata);
        end
        dm_addr   = 32'h3000;
        mem_ready = 1'b0;
        mem_rdata = '0;
        step();
        vectors++;
        if ({mem_valid, dm_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL b2b_no_grant_in_done got valid=%b dm_ready=%b exp 0 0", mem_valid, dm_ready);
        end
        step();
        vectors++;
        if ({mem_valid, mem_addr} !== {1'b1, 32'h3000}) begin
            miscompares++;
            $display("FAIL b2b_cmd2 got valid=%b addr=%h exp 1 00003000", mem_valid, mem_addr);
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h0BADF00D;
        step();
        vectors++;
        if (dm_ready !== 1'b1 || dm_rdata !== 32'h0BADF00D) begin
            miscompares++;
            $display("FAIL b2b_done2 got dm_ready=%b dm_rdata=%h exp 1 0badf00d", dm_ready, dm_rdata);
        end
        dm_req    = 1'b0;
        mem_ready = 1'b0;
        step();
        vectors++;
        if (dm_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_pulse_len got dm_ready=%b exp 0", dm_ready);
        end
    endtask

    // Store with 3-cycle memory latency; request inputs wiggle mid-transaction.
    task automatic test_store();
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h2004;
        dm_wdata = 32'hDEADBEEF;
        dm_be    = 4'b0011;
        step();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({mem_valid, mem_we, mem_addr, mem_wdata, mem_be, dm_ready} !==
                {1'b1, 1'b1, 32'h2004, 32'hDEADBEEF, 4'b0011, 1'b0}) begin
                miscompares++;
                $display("FAIL store_hold cyc=%0d got valid=%b we=%b addr=%h wdata=%h be=%h dm_ready=%b exp 1 1 00002004 deadbeef 3 0",
                         k, mem_valid, mem_we, mem_addr, mem_wdata, mem_be, dm_ready);
            end
            if (k == 0) begin
                dm_addr  = 32'hFFFF_FFF0;
                dm_wdata = 32'h0;
                dm_be    = 4'hF;
            end
            if (k == 2) begin
                mem_ready = 1'b1;
                mem_rdata = 32'h12345678;
            end
            step();
        end
        vectors++;
        if ({dm_ready, if_ready, mem_valid} !== 3'b100 || dm_rdata !== 32'h0BADF00D) begin
            miscompares++;
            $display("FAIL store_done got dm_ready=%b if_ready=%b valid=%b dm_rdata=%h exp 1 0 0 0badf00d",
                     dm_ready, if_ready, mem_valid, dm_rdata);
        end
        idle_inputs();
        step();
        vectors++;
        if (dm_ready !== 1'b0 || dm_rdata !== 32'h0BADF00D) begin
            miscompares++;
            $display("FAIL store_after got dm_ready=%b dm_rdata=%h exp 0 0badf00d", dm_ready, dm_rdata);
        end
    endtask

    // Both requests held: the fetch gets through after LIMIT consecutive data grants.
    task automatic test_starve();
        int   grants;
        int   starve_m;
        logic prev_valid;
        logic exp_is_if;
        logic got_is_if;
        grants     = 0;
        starve_m   = 0;
        prev_valid = 1'b0;
        if_req     = 1'b1;
        if_addr    = 32'h400;
        dm_req     = 1'b1;
        dm_we      = 1'b0;
        dm_addr    = 32'h800;
        for (int cyc = 0; cyc < 200 && grants < 10; cyc++) begin
            step();
            if (mem_valid && !prev_valid) begin
                exp_is_if = (starve_m == LIMIT);
                got_is_if = (mem_addr == 32'h400);
                vectors++;
                if (got_is_if !== exp_is_if) begin
                    miscompares++;
                    $display("FAIL starve_order grant=%0d got %s exp %s", grants,
                             got_is_if ? "IF" : "DM", exp_is_if ? "IF" : "DM");
                end
                starve_m  = exp_is_if ? 0 : ((starve_m < LIMIT) ? starve_m + 1 : starve_m);
                grants++;
                mem_ready = 1'b1;
                mem_rdata = 32'(grants);
            end else begin
                mem_ready = 1'b0;
            end
            prev_valid = mem_valid;
        end
        vectors++;
        if (grants != 10) begin
            miscompares++;
            $display("FAIL starve_timeout got %0d grants exp 10", grants);
        end
        step();
        vectors++;
        if ({if_ready, dm_ready} !== 2'b10 || if_rdata !== 32'd10) begin
            miscompares++;
            $display("FAIL starve_last got if_ready=%b dm_ready=%b if_rdata=%h exp 1 0 0000000a",
                     if_ready, dm_ready, if_rdata);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h5000;
        step();
        vectors++;
        if ({mem_valid, mem_addr} !== {1'b1, 32'h5000}) begin
            miscompares++;
            $display("FAIL rstmid_cmd got valid=%b addr=%h exp 1 00005000", mem_valid, mem_addr);
        end
        rst       = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFEBABE;
        step();
        vectors++;
        if ({mem_valid, mem_we, mem_addr, mem_wdata, mem_be, if_ready, dm_ready, if_rdata, dm_rdata} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_reset got valid=%b addr=%h dm_ready=%b if_rdata=%h dm_rdata=%h exp all zero",
                     mem_valid, mem_addr, dm_ready, if_rdata, dm_rdata);
        end
        rst    = 1'b0;
        dm_req = 1'b0;
        step();
        vectors++;
        if ({mem_valid, if_ready, dm_ready, dm_rdata} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_late_ready got valid=%b if_ready=%b dm_ready=%b dm_rdata=%h exp all zero",
                     mem_valid, if_ready, dm_ready, dm_rdata);
        end
        idle_inputs();
        step();
        vectors++;
        if ({mem_valid, dm_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL rstmid_idle got valid=%b dm_ready=%b exp 0 0", mem_valid, dm_ready);
        end
    endtask

    // Random requests and memory latency; the bench owns the memory contents.
    task automatic test_random();
        int          owner;
        int          cnt;
        int          starve_m;
        int          fetch_wait;
        int          issued;
        int          completed;
        logic        prev_valid, prev_idle, prev_drove, prev_if, prev_dm;
        logic        if_pend, dm_pend, own_dm, exp_grant;
        logic [31:0] exp_if_rdata, exp_dm_rdata, word;
        logic [31:0] r_if_addr, r_dm_addr, r_dm_wdata;
        logic        r_dm_we;
        logic [3:0]  r_dm_be;
        logic [31:0] s_addr, s_wdata;
        logic        s_we;
        logic [3:0]  s_be;

        for (int i = 0; i < 128; i++) mem_model[i] = $urandom;
        idle_inputs();
        owner = 0; cnt = 0; starve_m = 0; fetch_wait = 0; issued = 0; completed = 0;
        prev_valid = 1'b0; prev_idle = 1'b1; prev_drove = 1'b0; prev_if = 1'b0; prev_dm = 1'b0;
        if_pend = 1'b0; dm_pend = 1'b0;
        exp_if_rdata = '0; exp_dm_rdata = '0;
        r_if_addr = '0; r_dm_addr = '0; r_dm_wdata = '0; r_dm_we = 1'b0; r_dm_be = 4'h0;
        s_addr = '0; s_wdata = '0; s_we = 1'b0; s_be = 4'h0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            step();
            vectors++;
            if (if_ready !== (prev_drove && owner == 1) || dm_ready !== (prev_drove && owner == 2)) begin
                miscompares++;
                $display("FAIL rnd_ready cyc=%0d got if_ready=%b dm_ready=%b exp %b %b", cyc, if_ready, dm_ready,
                         prev_drove && owner == 1, prev_drove && owner == 2);
            end
            vectors++;
            if (if_ready && dm_ready) begin
                miscompares++;
                $display("FAIL rnd_both_ready cyc=%0d got 1 1 exp at most one", cyc);
            end
            vectors++;
            if (if_rdata !== exp_if_rdata || dm_rdata !== exp_dm_rdata) begin
                miscompares++;
                $display("FAIL rnd_rdata cyc=%0d got if=%h dm=%h exp if=%h dm=%h", cyc, if_rdata, dm_rdata,
                         exp_if_rdata, exp_dm_rdata);
            end

            if (prev_drove) begin
                vectors++;
                if (mem_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rnd_release cyc=%0d got valid=%b exp 0", cyc, mem_valid);
                end
                if (owner == 1) if_pend = 1'b0;
                else dm_pend = 1'b0;
                completed++;
                owner = 0;
            end else if (prev_valid) begin
                vectors++;
                if ({mem_valid, mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, s_we, s_addr, s_wdata, s_be}) begin
                    miscompares++;
                    $display("FAIL rnd_hold cyc=%0d got valid=%b we=%b addr=%h wdata=%h be=%h exp 1 %b %h %h %h",
                             cyc, mem_valid, mem_we, mem_addr, mem_wdata, mem_be, s_we, s_addr, s_wdata, s_be);
                end
            end else begin
                exp_grant = prev_idle && (prev_if || prev_dm);
                vectors++;
                if (mem_valid !== exp_grant) begin
                    miscompares++;
                    $display("FAIL rnd_grant cyc=%0d got valid=%b exp %b", cyc, mem_valid, exp_grant);
                end
                if (mem_valid) begin
                    own_dm = prev_dm && !(prev_if && starve_m == LIMIT);
                    if (own_dm) begin
                        s_we = r_dm_we; s_addr = r_dm_addr; s_wdata = r_dm_wdata; s_be = r_dm_be;
                        owner    = 2;
                        starve_m = prev_if ? ((starve_m < LIMIT) ? starve_m + 1 : starve_m) : 0;
                    end else begin
                        s_we = 1'b0; s_addr = r_if_addr; s_wdata = '0; s_be = 4'hF;
                        owner    = 1;
                        starve_m = 0;
                    end
                    vectors++;
                    if ({mem_we, mem_addr, mem_wdata, mem_be} !== {s_we, s_addr, s_wdata, s_be}) begin
                        miscompares++;
                        $display("FAIL rnd_cmd cyc=%0d got we=%b addr=%h wdata=%h be=%h exp %b %h %h %h",
                                 cyc, mem_we, mem_addr, mem_wdata, mem_be, s_we, s_addr, s_wdata, s_be);
                    end
                    // Fetch wait measured from what the DUT actually granted (bit 8 marks data addresses).
                    fetch_wait = (mem_addr[8] && prev_if) ? fetch_wait + 1 : 0;
                    vectors++;
                    if (fetch_wait > LIMIT) begin
                        miscompares++;
                        $display("FAIL rnd_fetch_wait cyc=%0d got %0d data grants exp <= %0d", cyc, fetch_wait, LIMIT);
                    end
                    cnt = $urandom_range(1, 8);
                end
            end

            prev_drove = 1'b0;
            mem_ready  = 1'b0;
            mem_rdata  = $urandom;
            if (owner != 0 && mem_valid) begin
                cnt--;
                if (cnt == 0) begin
                    mem_ready  = 1'b1;
                    prev_drove = 1'b1;
                    if (s_we) begin
                        word = mem_model[s_addr[8:2]];
                        for (int b = 0; b < 4; b++)
                            if (s_be[b]) word[8*b +: 8] = s_wdata[8*b +: 8];
                        mem_model[s_addr[8:2]] = word;
                    end else begin
                        word      = mem_model[s_addr[8:2]];
                        mem_rdata = word;
                        if (owner == 1) exp_if_rdata = word;
                        else exp_dm_rdata = word;
                    end
                end
            end else if (!mem_valid && $urandom_range(0, 3) == 0) begin
                mem_ready = 1'b1;
            end

            if (!if_pend && cyc < 3500 && $urandom_range(0, 2) == 0) begin
                if_pend   = 1'b1;
                r_if_addr = 32'(4 * $urandom_range(0, 63));
                issued++;
            end
            if (!dm_pend && cyc < 3500 && $urandom_range(0, 1) == 0) begin
                dm_pend    = 1'b1;
                r_dm_addr  = 32'h100 + 32'(4 * $urandom_range(0, 63));
                r_dm_we    = 1'($urandom_range(0, 1));
                r_dm_wdata = $urandom;
                r_dm_be    = 4'($urandom_range(1, 15));
                issued++;
            end
            if_req   = if_pend;
            if_addr  = if_pend ? r_if_addr : $urandom;
            dm_req   = dm_pend;
            dm_addr  = dm_pend ? r_dm_addr : $urandom;
            dm_we    = dm_pend ? r_dm_we : 1'($urandom_range(0, 1));
            dm_wdata = dm_pend ? r_dm_wdata : $urandom;
            dm_be    = dm_pend ? r_dm_be : 4'($urandom_range(0, 15));

            prev_valid = mem_valid;
            prev_idle  = !mem_valid && !if_ready && !dm_ready;
            prev_if    = if_req;
            prev_dm    = dm_req;
        end
        vectors++;
        if (if_pend || dm_pend || issued != completed) begin
            miscompares++;
            $display("FAIL rnd_lost got completed=%0d pending if=%b dm=%b exp completed=%0d none pending",
                     completed, if_pend, dm_pend, issued);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_back_to_back();
        test_store();
        test_starve();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
